// File: rtl/req_gnt_mon_pkg.sv
// Shared types and helpers for the request/grant handshake monitor.
package req_gnt_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        EARLY,
        TIMEOUT,
        DROP,
        SPURIOUS
    } viol_e;

    // Latency counter width: ceil(log2(max_lat+1)), never below one bit.
    function automatic int lat_w(input int max_lat);
        return (max_lat < 2) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/req_gnt_chk_ch.sv
// One channel of the req/gnt monitor: FSM, latency counter, registered flags.
module req_gnt_chk_ch
    import req_gnt_mon_pkg::*;
#(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req,
    input  logic gnt,
    output logic pass,
    output logic err_early,
    output logic err_timeout,
    output logic err_drop,
    output logic err_spurious,
    output logic hit_pass,
    output logic hit_err
);

    localparam int KW = lat_w(MAX_LAT);
    localparam logic [KW:0]   MIN_K   = (KW+1)'(MIN_LAT);
    localparam logic [KW-1:0] MAX_K   = KW'(MAX_LAT);
    localparam bit            ZERO_OK = (MIN_LAT == 0);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    viol_e           viol;
    logic            ok;
    logic            late_enough;

    // k >= MIN_LAT, phrased as k+1 > MIN_LAT so MIN_LAT=0 is not a const compare
    assign late_enough = ({1'b0, k_q} + (KW+1)'(1)) > MIN_K;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        viol    = NONE;
        ok      = 1'b0;
        if (!en) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && gnt) begin
                        state_d = HOLD;
                        if (ZERO_OK) ok = 1'b1;
                        else         viol = EARLY;
                    end else if (req) begin
                        state_d = WAIT;
                        k_d     = KW'(1);
                    end else if (gnt) begin
                        viol = SPURIOUS;
                    end
                end
                WAIT: begin
                    if (gnt) begin
                        state_d = HOLD;
                        k_d     = '0;
                        if (late_enough) ok = 1'b1;
                        else             viol = EARLY;
                    end else if (!req) begin
                        state_d = IDLE;
                        k_d     = '0;
                        viol    = DROP;
                    end else if (k_q == MAX_K) begin
                        state_d = HOLD;
                        k_d     = '0;
                        viol    = TIMEOUT;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                HOLD: begin
                    if (!req) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    assign hit_pass = ok;
    assign hit_err  = (viol != NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            pass         <= 1'b0;
            err_early    <= 1'b0;
            err_timeout  <= 1'b0;
            err_drop     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pass         <= ok;
            err_early    <= (viol == EARLY);
            err_timeout  <= (viol == TIMEOUT);
            err_drop     <= (viol == DROP);
            err_spurious <= (viol == SPURIOUS);
        end
    end

endmodule

// File: rtl/req_gnt_monitor.sv
// Multi-channel req/gnt latency-window monitor with saturating counters.
module req_gnt_monitor
    import req_gnt_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] gnt,
    output logic [NUM_CH-1:0] pass,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_timeout,
    output logic [NUM_CH-1:0] err_drop,
    output logic [NUM_CH-1:0] err_spurious,
    output logic              err_any,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] hit_pass, hit_err;
    logic [PW-1:0]     n_pass, n_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_gnt_chk_ch #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .req          (req[i]),
            .gnt          (gnt[i]),
            .pass         (pass[i]),
            .err_early    (err_early[i]),
            .err_timeout  (err_timeout[i]),
            .err_drop     (err_drop[i]),
            .err_spurious (err_spurious[i]),
            .hit_pass     (hit_pass[i]),
            .hit_err      (hit_err[i])
        );
    end

    always_comb begin
        n_pass = '0;
        n_err  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_pass = n_pass + PW'(hit_pass[i]);
            n_err  = n_err + PW'(hit_err[i]);
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [PW-1:0]    b
    );
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
    endfunction

    // Counters see the same-edge pulse decisions, so they move with the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_any  <= 1'b0;
        end else if (clr) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
            err_any  <= 1'b0;
        end else begin
            pass_cnt <= sat_add(pass_cnt, n_pass);
            err_cnt  <= sat_add(err_cnt, n_err);
            err_any  <= err_any | (|hit_err);
        end
    end

endmodule

// File: tb/tb_req_gnt_monitor.sv
// Directed and randomized bench for req_gnt_monitor against a timestamp model.
module tb_req_gnt_monitor;

    localparam int NUM_CH  = 4;
    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 4;
    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] gnt = '0;
    logic [NUM_CH-1:0] pass, err_early, err_timeout, err_drop, err_spurious;
    logic              err_any;
    logic [CNT_W-1:0]  pass_cnt, err_cnt;

    req_gnt_monitor #(
        .NUM_CH  (NUM_CH),
        .MIN_LAT (MIN_LAT),
        .MAX_LAT (MAX_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .req          (req),
        .gnt          (gnt),
        .pass         (pass),
        .err_early    (err_early),
        .err_timeout  (err_timeout),
        .err_drop     (err_drop),
        .err_spurious (err_spurious),
        .err_any      (err_any),
        .pass_cnt     (pass_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Model: each channel is free, pending since a timestamp, or held
    typedef enum {M_FREE, M_PEND, M_HELD} mmode_e;

    mmode_e            mode [NUM_CH];
    int                t_req [NUM_CH];
    int                cyc;
    logic [NUM_CH-1:0] e_pass, e_early, e_to, e_drop, e_spur;
    int                e_pcnt, e_ecnt;
    logic              e_any;
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mode[i]  = M_FREE;
            t_req[i] = 0;
        end
        e_pass = '0; e_early = '0; e_to = '0; e_drop = '0; e_spur = '0;
        e_pcnt = 0; e_ecnt = 0; e_any = 1'b0;
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] r,
                              input logic [NUM_CH-1:0] g,
                              input logic e, input logic c);
        int lat;
        logic [NUM_CH-1:0] errs;
        e_pass = '0; e_early = '0; e_to = '0; e_drop = '0; e_spur = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!e) begin
                mode[i] = M_FREE;
            end else if (mode[i] == M_FREE) begin
                if (r[i] && g[i]) begin
                    mode[i] = M_HELD;
                    if (MIN_LAT == 0) e_pass[i] = 1'b1;
                    else              e_early[i] = 1'b1;
                end else if (r[i]) begin
                    mode[i]  = M_PEND;
                    t_req[i] = cyc;
                end else if (g[i]) begin
                    e_spur[i] = 1'b1;
                end
            end else if (mode[i] == M_PEND) begin
                lat = cyc - t_req[i];
                if (g[i]) begin
                    mode[i] = M_HELD;
                    if (lat >= MIN_LAT) e_pass[i] = 1'b1;
                    else                e_early[i] = 1'b1;
                end else if (!r[i]) begin
                    mode[i]   = M_FREE;
                    e_drop[i] = 1'b1;
                end else if (lat >= MAX_LAT) begin
                    mode[i] = M_HELD;
                    e_to[i] = 1'b1;
                end
            end else if (!r[i]) begin
                mode[i] = M_FREE;
            end
        end
        errs = e_early | e_to | e_drop | e_spur;
        if (c) begin
            e_pcnt = 0; e_ecnt = 0; e_any = 1'b0;
        end else begin
            e_pcnt = e_pcnt + $countones(e_pass);
            e_ecnt = e_ecnt + $countones(errs);
            if (e_pcnt > CMAX) e_pcnt = CMAX;
            if (e_ecnt > CMAX) e_ecnt = CMAX;
            e_any = e_any | (|errs);
        end
    endtask

    task automatic check_all();
        chk("pass", pass, e_pass);
        chk("err_early", err_early, e_early);
        chk("err_timeout", err_timeout, e_to);
        chk("err_drop", err_drop, e_drop);
        chk("err_spurious", err_spurious, e_spur);
        chk("err_any", err_any, e_any);
        chk("pass_cnt", pass_cnt, e_pcnt);
        chk("err_cnt", err_cnt, e_ecnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_errs"}, err_early | err_timeout | err_drop | err_spurious, 0);
        chk({tag, "_any"}, err_any, 0);
        chk({tag, "_pcnt"}, pass_cnt, 0);
        chk({tag, "_ecnt"}, err_cnt, 0);
    endtask

    task automatic step(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] g,
                        input logic e = 1'b1, input logic c = 1'b0);
        req = r; gnt = g; en = e; clr = c;
        @(posedge clk);
        cyc++;
        model_edge(r, g, e, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [NUM_CH-1:0] rr, gg;
        logic              ee, cc;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        // ch0 legal handshake at latency 1
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0001);
        chk("ch0_pass", pass, 4'b0001);
        chk("ch0_pcnt", pass_cnt, 1);
        step(4'b0000, 4'b0000);
        chk("ch0_any", err_any, 0);
        // ch1 request and grant together
        step(4'b0010, 4'b0010);
        chk("ch1_early", err_early, 4'b0010);
        chk("ch1_ecnt", err_cnt, 1);
        chk("ch1_any", err_any, 1);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        // ch2 never granted
        step(4'b0100, 4'b0000);
        repeat (3) step(4'b0100, 4'b0000);
        chk("ch2_not_yet", err_timeout, 0);
        step(4'b0100, 4'b0000);
        chk("ch2_timeout", err_timeout, 4'b0100);
        repeat (4) step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0000);
        // ch3 drop, then spurious grant
        step(4'b1000, 4'b0000);
        step(4'b1000, 4'b0000);
        step(4'b0000, 4'b0000);
        chk("ch3_drop", err_drop, 4'b1000);
        step(4'b0000, 4'b1000);
        chk("ch3_spur", err_spurious, 4'b1000);
        chk("ch3_ecnt", err_cnt, 4);
        // clr coinciding with a pass still pulses but does not count
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 1'b1, 1'b1);
        chk("clr_pulse", pass, 4'b0001);
        chk("clr_pcnt", pass_cnt, 0);
        step(4'b0000, 4'b0000);
        // saturation: all channels granted at k=2
        for (int n = 0; n < 70; n++) begin
            step(4'b1111, 4'b0000);
            step(4'b1111, 4'b0000);
            step(4'b1111, 4'b1111);
            step(4'b0000, 4'b0000);
        end
        chk("sat_pcnt", pass_cnt, CMAX);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        check_zero("after_clr");
        // en low forces channels idle
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 1'b0);
        chk("en_off_pass", pass, 0);
        step(4'b0001, 4'b0001);
        chk("en_back_early", err_early, 4'b0001);
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0010);
        step(4'b0000, 4'b0000);
        // reset in the middle of a wait at k=2
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0001);
        chk("post_reset_pass", pass, 4'b0001);
        chk("post_reset_err", err_cnt, 0);
        step(4'b0000, 4'b0000);
        // random traffic
        rr = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 3) == 0) rr[i] = ~rr[i];
                gg[i] = ($urandom_range(0, 2) == 0);
            end
            ee = ($urandom_range(0, 49) != 0);
            cc = ee && ($urandom_range(0, 99) == 0);
            step(rr, gg, ee, cc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
